// File: rtl/mem_req_arbiter_if.sv
// Bundle of requester-side and RAM-side signals of the memory request arbiter.
// Handshake: a channel holds (req_ren|req_wen) with stable addr/wdata until its one-cycle req_ready pulse; the RAM holds ram_busy high until the access is done.
interface mem_req_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [NUM_CH-1:0]        req_ren;
  logic [NUM_CH-1:0]        req_wen;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH*DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0]        req_rdata;
  logic [NUM_CH-1:0]        req_ready;
  logic [ADDR_W-1:0]        ram_addr;
  logic [DATA_W-1:0]        ram_wdata;
  logic                     ram_ren;
  logic                     ram_wen;
  logic [DATA_W-1:0]        ram_rdata;
  logic                     ram_busy;

  // The arbiter serves the bundle; the environment (requesters + RAM) drives it.
  modport slave (
    input  req_ren, req_wen, req_addr, req_wdata, ram_rdata, ram_busy,
    output req_rdata, req_ready, ram_addr, ram_wdata, ram_ren, ram_wen
  );

  modport master (
    output req_ren, req_wen, req_addr, req_wdata, ram_rdata, ram_busy,
    input  req_rdata, req_ready, ram_addr, ram_wdata, ram_ren, ram_wen
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// Multi-channel arbiter funnelling read/write requests into one single-port RAM.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (lowest index wins).
module mem_req_arbiter #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               CLK,
  input  logic               RST,
  mem_req_arbiter_if.slave   bus,
  output logic [1:0]         dbg_state
);

  localparam int IDX_W = $clog2(NUM_CH);
  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  idx_t                win_q, win_d;
  idx_t                pick;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                wr_q, wr_d;
  logic [NUM_CH-1:0]   req_any;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  idx_t                ptr_q, ptr_d;
`endif

  assign req_any   = bus.req_ren | bus.req_wen;
  assign dbg_state = state_q;

  // Descending scan so the candidate closest to the search start is assigned last and wins.
  always_comb begin
    pick = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req_any[idx_t'((int'(ptr_q) + k) % NUM_CH)]) begin
        pick = idx_t'((int'(ptr_q) + k) % NUM_CH);
      end
    end
`else
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req_any[idx_t'(k)]) begin
        pick = idx_t'(k);
      end
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wr_d    = wr_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req_any) begin
          state_d = ACCESS;
          win_d   = pick;
          addr_d  = bus.req_addr[int'(pick)*ADDR_W +: ADDR_W];
          wdata_d = bus.req_wdata[int'(pick)*DATA_W +: DATA_W];
          wr_d    = bus.req_wen[pick];
`ifdef MEM_ARB_ROUND_ROBIN_EN
          ptr_d   = idx_t'((int'(pick) + 1) % NUM_CH);
`endif
        end
      end
      ACCESS: begin
        if (!bus.ram_busy) begin
          rdata_d = bus.ram_rdata;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode only registered state, so nothing combinational leaks from the request inputs.
  always_comb begin
    bus.req_ready = '0;
    bus.req_rdata = '0;
    bus.ram_ren   = 1'b0;
    bus.ram_wen   = 1'b0;
    bus.ram_addr  = addr_q;
    bus.ram_wdata = wdata_q;
    if (state_q == ACCESS) begin
      bus.ram_ren = !wr_q;
      bus.ram_wen = wr_q;
    end
    if (state_q == RESP) begin
      bus.req_ready[win_q] = 1'b1;
      bus.req_rdata        = rdata_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      win_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed scenarios plus randomized requesters against a transaction-level model.
module tb_mem_req_arbiter;
  localparam int NUM_CH = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // ---------------- clock / reset ----------------
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] dbg_state;

  always #5 CLK = ~CLK;

  mem_req_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  mem_req_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- requester / RAM stimulus state ----------------
  logic              ch_ren   [NUM_CH];
  logic              ch_wen   [NUM_CH];
  logic [ADDR_W-1:0] ch_addr  [NUM_CH];
  logic [DATA_W-1:0] ch_wdata [NUM_CH];
  bit                ch_active[NUM_CH];
  int                ch_left  [NUM_CH];
  bit                rand_mode = 1'b0;

  logic [7:0] exp_q[$];
  int         got_q[$];

  task automatic apply();
    for (int c = 0; c < NUM_CH; c++) begin
      bus.req_ren[c] = ch_ren[c];
      bus.req_wen[c] = ch_wen[c];
      bus.req_addr[c*ADDR_W +: ADDR_W]  = ch_addr[c];
      bus.req_wdata[c*DATA_W +: DATA_W] = ch_wdata[c];
    end
  endtask

  task automatic clear_chans();
    for (int c = 0; c < NUM_CH; c++) begin
      ch_ren[c] = 1'b0; ch_wen[c] = 1'b0; ch_addr[c] = '0; ch_wdata[c] = '0;
      ch_active[c] = 1'b0; ch_left[c] = 0;
    end
    apply();
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    clear_chans();
    bus.ram_busy  = 1'b0;
    bus.ram_rdata = '0;
    cyc();
    cyc();
    RST = 1'b0;
  endtask

  // ---------------- behavioural model ----------------
  // One outstanding transaction at most; it is granted from idle, occupies the RAM
  // until a non-busy edge, then is answered for one cycle before the next grant.
  bit                m_in_ram, m_answer;
  int                m_win, m_ptr;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_rdata;
  bit                m_wr;

  always @(posedge CLK) begin
    int w;
    int c;
    if (RST) begin
      m_in_ram = 0; m_answer = 0; m_win = 0; m_ptr = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0; m_wr = 0;
      exp_q.delete();
    end else if (m_answer) begin
      m_answer = 0;
    end else if (m_in_ram) begin
      if (!bus.ram_busy) begin
        m_rdata  = bus.ram_rdata;
        m_in_ram = 0;
        m_answer = 1;
      end
    end else begin
      w = -1;
      for (int k = 0; k < NUM_CH; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        c = (m_ptr + k) % NUM_CH;
`else
        c = k;
`endif
        if (w < 0 && (ch_ren[c] || ch_wen[c])) w = c;
      end
      if (w >= 0) begin
        m_win    = w;
        m_addr   = ch_addr[w];
        m_wdata  = ch_wdata[w];
        m_wr     = ch_wen[w];
        m_in_ram = 1;
        m_ptr    = (w + 1) % NUM_CH;
        exp_q.push_back(8'(w));
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    if (chk_en) begin
      check("req_ready", 64'(bus.req_ready), m_answer ? (64'd1 << m_win) : 64'd0);
      check("req_rdata", 64'(bus.req_rdata), m_answer ? 64'(m_rdata) : 64'd0);
      check("ram_ren",   64'(bus.ram_ren),   64'(m_in_ram && !m_wr));
      check("ram_wen",   64'(bus.ram_wen),   64'(m_in_ram && m_wr));
      check("ram_addr",  64'(bus.ram_addr),  64'(m_addr));
      check("ram_wdata", 64'(bus.ram_wdata), 64'(m_wdata));
    end
  end

  // ---------------- requester agents (called at posedge+1) ----------------
  task automatic start_req(int c);
    ch_active[c] = 1'b1;
    if (rand_mode) begin
      ch_ren[c]   = 1'($urandom_range(0, 1));
      ch_wen[c]   = 1'($urandom_range(0, 1));
      if (!ch_ren[c] && !ch_wen[c]) ch_ren[c] = 1'b1;
      ch_addr[c]  = $urandom;
      ch_wdata[c] = $urandom;
    end else begin
      ch_ren[c]   = 1'b1;
      ch_wen[c]   = 1'b0;
      ch_addr[c]  = 32'h1000 + 32'(c * 16 + ch_left[c]);
      ch_wdata[c] = 32'hA000 + 32'(c);
    end
  endtask

  task automatic stop_req(int c);
    ch_active[c] = 1'b0;
    ch_ren[c]    = 1'b0;
    ch_wen[c]    = 1'b0;
  endtask

  task automatic agent_step();
    logic [NUM_CH-1:0] rdy;
    logic [7:0]        exp_ch;
    rdy = bus.req_ready;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rdy[c]) begin
        got_q.push_back(c);
        if (exp_q.size() == 0) begin
          check("sb_unexpected_ready", 64'(c), 64'hFF);
        end else begin
          exp_ch = exp_q.pop_front();
          check("sb_grant_channel", 64'(c), 64'(exp_ch));
        end
        stop_req(c);
        if (ch_left[c] > 0) ch_left[c]--;
      end
      if (rand_mode) begin
        if (ch_active[c] && $urandom_range(0, 99) < 3) stop_req(c);
        else if (!ch_active[c] && $urandom_range(0, 99) < 35) start_req(c);
      end else if (!ch_active[c] && ch_left[c] > 0) begin
        start_req(c);
      end
    end
    bus.ram_busy  = ($urandom_range(0, 99) < 40);
    bus.ram_rdata = $urandom;
    if (rand_mode) RST = ($urandom_range(0, 149) == 0);
    apply();
  endtask

  task automatic run_until_drained(int budget);
    bit busy_left;
    int n;
    n = 0;
    busy_left = 1'b1;
    while (busy_left && n < budget) begin
      cyc();
      agent_step();
      n++;
      busy_left = 1'b0;
      for (int c = 0; c < NUM_CH; c++) if (ch_left[c] > 0) busy_left = 1'b1;
    end
    check("drain_timeout", 64'(busy_left), 64'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  int wen_cnt;
  int exp_order[5];

  initial begin
    bus.ram_busy  = 1'b0;
    bus.ram_rdata = '0;
    clear_chans();
    do_reset();
    chk_en = 1'b1;

    // reset state
    @(negedge CLK);
    check("rst_ready", 64'(bus.req_ready), 64'd0);
    check("rst_ren_wen", 64'({bus.ram_ren, bus.ram_wen}), 64'd0);
    check("rst_addr", 64'(bus.ram_addr), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);

    // single read on the instruction port
    do_reset();
    ch_ren[1] = 1'b1; ch_addr[1] = 32'h40;
    bus.ram_rdata = 32'hDEADBEEF;
    apply();
    cyc();
    @(negedge CLK);
    check("rd_access_ren", 64'(bus.ram_ren), 64'd1);
    check("rd_access_addr", 64'(bus.ram_addr), 64'h40);
    check("rd_access_ready", 64'(bus.req_ready), 64'd0);
    cyc();
    @(negedge CLK);
    check("rd_resp_ready", 64'(bus.req_ready), 64'b0010);
    check("rd_resp_rdata", 64'(bus.req_rdata), 64'hDEADBEEF);
    check("rd_resp_ren", 64'(bus.ram_ren), 64'd0);
    ch_ren[1] = 1'b0; apply();
    cyc();
    @(negedge CLK);
    check("rd_after_ready", 64'(bus.req_ready), 64'd0);
    check("rd_addr_held", 64'(bus.ram_addr), 64'h40);

    // write stretched by 4 busy cycles
    do_reset();
    ch_wen[0] = 1'b1; ch_addr[0] = 32'h100; ch_wdata[0] = 32'h12345678;
    bus.ram_busy = 1'b1;
    apply();
    cyc();
    wen_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      bus.ram_busy = (i < 4);
      @(negedge CLK);
      if (bus.ram_wen && bus.ram_addr == 32'h100 && bus.ram_wdata == 32'h12345678) wen_cnt++;
      cyc();
    end
    check("busy_wen_cycles", 64'(wen_cnt), 64'd5);
    @(negedge CLK);
    check("busy_resp_ready", 64'(bus.req_ready), 64'b0001);
    check("busy_resp_wen", 64'(bus.ram_wen), 64'd0);
    ch_wen[0] = 1'b0; apply();
    cyc();
    @(negedge CLK);
    check("busy_single_pulse", 64'(bus.req_ready), 64'd0);

    // two channels contending, two transactions each
    do_reset();
    got_q.delete();
    ch_left[0] = 2; ch_left[1] = 2;
    agent_step();
    run_until_drained(200);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1, -1};
`else
    exp_order = '{0, 0, 1, 1, -1};
`endif
    check("cont2_count", 64'(got_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) check("cont2_order", 64'(i < got_q.size() ? got_q[i] : -1), 64'(exp_order[i]));

    // all four channels contending, ch0 wants two
    do_reset();
    got_q.delete();
    ch_left[0] = 2; ch_left[1] = 1; ch_left[2] = 1; ch_left[3] = 1;
    agent_step();
    run_until_drained(300);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 2, 3, 0};
`else
    exp_order = '{0, 0, 1, 2, 3};
`endif
    check("cont4_count", 64'(got_q.size()), 64'd5);
    for (int i = 0; i < 5; i++) check("cont4_order", 64'(i < got_q.size() ? got_q[i] : -1), 64'(exp_order[i]));

    // reset during the second busy access cycle
    do_reset();
    ch_ren[0] = 1'b1; ch_addr[0] = 32'h200;
    bus.ram_busy = 1'b1;
    apply();
    cyc();
    cyc();
    RST = 1'b1;
    @(negedge CLK);
    check("mrst_in_access", 64'(bus.ram_ren), 64'd1);
    cyc();
    @(negedge CLK);
    check("mrst_ren_wen", 64'({bus.ram_ren, bus.ram_wen}), 64'd0);
    check("mrst_ready", 64'(bus.req_ready), 64'd0);
    check("mrst_state", 64'(dbg_state), 64'd0);
    RST = 1'b0; ch_ren[0] = 1'b0; bus.ram_busy = 1'b0; apply();
    cyc();
    cyc();
    @(negedge CLK);
    check("mrst_no_pulse", 64'(bus.req_ready), 64'd0);

    // read and write together on one channel: write wins
    do_reset();
    ch_ren[0] = 1'b1; ch_wen[0] = 1'b1; ch_addr[0] = 32'h300; ch_wdata[0] = 32'h55AA55AA;
    apply();
    cyc();
    @(negedge CLK);
    check("dual_wen", 64'(bus.ram_wen), 64'd1);
    check("dual_ren", 64'(bus.ram_ren), 64'd0);
    cyc();
    ch_ren[0] = 1'b0; ch_wen[0] = 1'b0; apply();
    cyc();

    // randomized traffic
    do_reset();
    rand_mode = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      cyc();
      agent_step();
    end
    rand_mode = 1'b0;
    RST = 1'b0;
    clear_chans();
    for (int n = 0; n < 20; n++) begin
      cyc();
      agent_step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning number of requester channels (legal range 2..8); channel 0 is the data port and channel 1 is the instruction port.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-003 SHALL have parameter DATA_W, default 32, meaning data width.
REQ-004 SHALL have port CLK, input, 1, the single clock; all logic is on the rising edge.
REQ-005 SHALL have port RST, input, 1, the reset; reset is synchronous and active-high.
REQ-006 SHALL have port req_ren, input, NUM_CH, the per-channel read request.
REQ-007 SHALL have port req_wen, input, NUM_CH, the per-channel write request.
REQ-008 SHALL have port req_addr, input, NUM_CH*ADDR_W, the flattened per-channel address, with channel i at bits [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port req_wdata, input, NUM_CH*DATA_W, the flattened per-channel store data.
REQ-010 SHALL have port req_rdata, output, DATA_W, the shared load data, valid while req_ready is asserted.
REQ-011 SHALL have port req_ready, output, NUM_CH, a one-hot completion pulse.
REQ-012 SHALL have port ram_addr, output, ADDR_W, the RAM address.
REQ-013 SHALL have port ram_wdata, output, DATA_W, the RAM store data.
REQ-014 SHALL have port ram_ren, output, 1, the RAM read enable.
REQ-015 SHALL have port ram_wen, output, 1, the RAM write enable.
REQ-016 SHALL have port ram_rdata, input, DATA_W, the RAM load data.
REQ-017 SHALL have port ram_busy, input, 1, asserted by the RAM while an access is not yet complete.

Function
REQ-018 SHALL implement a three-state FSM with states IDLE, ACCESS and RESP.
REQ-019 In IDLE, when any channel has (req_ren|req_wen) asserted, the FSM SHALL pick one winner, latch its index, address, wdata and op, and go to ACCESS on the next edge.
REQ-020 When a winner is picked, its write SHALL take precedence over a read if both req_wen and req_ren are set on that channel.
REQ-021 In ACCESS, the latched address and data SHALL drive ram_addr and ram_wdata, and exactly one of ram_ren/ram_wen SHALL be 1 per the latched op.
REQ-022 ACCESS SHALL persist while ram_busy=1, with the latched values held stable.
REQ-023 In ACCESS with ram_busy=0, on the edge the module SHALL capture ram_rdata into the rdata register and go to RESP.
REQ-024 In RESP, req_ready[winner] SHALL be 1 for exactly one cycle, req_rdata SHALL hold the captured data, ram_ren and ram_wen SHALL be 0, and the next state SHALL be IDLE.
REQ-025 A request SHALL complete in a minimum of 3 cycles (IDLE sample, ACCESS, RESP) plus 1 cycle per cycle of ram_busy=1.
REQ-026 Requests arriving during ACCESS or RESP SHALL NOT be granted until the next IDLE; requesters hold requests until they see req_ready.
REQ-027 Any request still asserted in the cycle after RESP SHALL be treated as a new transaction.
REQ-028 Outside ACCESS, ram_ren and ram_wen SHALL be 0, and ram_addr and ram_wdata SHALL hold their last latched value.
REQ-029 A channel that drops its request during ACCESS SHALL NOT abort the access; the transaction SHALL complete normally.
REQ-030 In IDLE with no request, the module SHALL stay in IDLE with all outputs 0 except the held values in REQ-028.

Reset
REQ-031 With RST=1 at an edge, the module SHALL go to IDLE and clear ram_ren, ram_wen, req_ready, req_rdata, ram_addr, ram_wdata and the round-robin pointer to 0.
REQ-032 A reset asserted mid-ACCESS SHALL abandon the access, with no req_ready pulse issued.

Configuration
REQ-033 With macro MEM_ARB_ROUND_ROBIN_EN defined, arbitration SHALL be round-robin: the search starts at (last winner + 1) mod NUM_CH, and the pointer updates on each grant.
REQ-034 Without MEM_ARB_ROUND_ROBIN_EN, arbitration SHALL be fixed priority with the lowest index winning, so data beats instruction, and there SHALL be no pointer state.

Verification
REQ-035 Single read: with ch1 ren and addr=0x40, ram_busy=0, ram_rdata=0xDEADBEEF -> ram_ren=1 for 1 cycle with ram_addr=0x40, then req_ready=2'b10 with req_rdata=0xDEADBEEF in the 3rd cycle.
REQ-036 Busy stretch: with ch0 wen, addr=0x100, wdata=0x12345678, ram_busy=1 for 4 cycles -> ram_wen=1 for 5 cycles with stable addr and data, then req_ready=2'b01 once.
REQ-037 Contention, fixed priority: with ch0 and ch1 requesting continuously for 2 transactions each -> grant order ch0, ch0, then ch1, ch1.
REQ-038 Contention, with MEM_ARB_ROUND_ROBIN_EN and NUM_CH=4, all four channels requesting -> grant order 0,1,2,3,0.
REQ-039 Mid-access reset: with RST=1 during the 2nd ACCESS cycle with ram_busy=1 -> the next cycle shows ram_ren=0, ram_wen=0 and req_ready=0, and the FSM is in IDLE.
REQ-040 Dual op: with ch0 ren=1 and wen=1 on the same cycle -> ram_wen=1 and ram_ren=0 during ACCESS.
